mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mult_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared constants for the iterative multiply/divide unit: the operation
// encodings seen on the op port, the ALU-level op group decode bits, the
// FSM state encodings and the iteration count.
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

   // op port encodings
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // op[1] selects the divide group, op[0] selects unsigned operation
   localparam int OP_BIT_DIV      = 1;
   localparam int OP_BIT_UNSIGNED = 0;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // radix-2 iterations per operation
   localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Iterative 32x32 multiply / divide unit, one radix-2 step per clock.
// Signed ops run on magnitudes; signs are applied to the final result only,
// so hi/lo never show intermediate values.
//
// Ports
//   clk    : clock, all state changes on rising edge
//   reset  : synchronous active-high reset
//   a      : multiplicand / dividend (sampled on accepted start)
//   b      : multiplier / divisor    (sampled on accepted start)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start  : request a new operation (accepted in IDLE or DONE)
//   busy   : high while in RUN
//   done   : one-cycle pulse when hi/lo take a new result
//   hi, lo : product[63:32]/[31:0] or remainder/quotient
//
// FSM
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start, hi/lo hold last result
//   ST_RUN  | one shift-add / shift-subtract step per cycle, 32 cycles
//   ST_DONE | done=1 for this cycle; start here launches back-to-back
// ----------------------------------------------------------------------------
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W = WIDTH;

   logic [1:0]     r_state;
   logic [5:0]     r_cnt;
   logic [W-1:0]   r_opnd;
   logic [2*W-1:0] r_wrk;
   logic           r_is_div;
   logic           r_neg_q;
   logic           r_neg_r;
   logic [W-1:0]   r_hi;
   logic [W-1:0]   r_lo;

   logic           w_accept;
   logic           w_signed;
   logic           w_neg_a;
   logic           w_neg_b;
   logic           w_b_zero;
   logic [W-1:0]   w_abs_a;
   logic [W-1:0]   w_abs_b;
   logic [W-1:0]   w_wrk_hi;
   logic [W-1:0]   w_wrk_lo;
   logic [W:0]     w_add_x;
   logic [W:0]     w_add_y;
   logic           w_add_c;
   logic [W:0]     w_sum;
   logic [W-1:0]   w_nxt_hi;
   logic [W-1:0]   w_nxt_lo;
   logic [2*W-1:0] w_prod_neg;
   logic [W-1:0]   w_res_hi;
   logic [W-1:0]   w_res_lo;
   logic           w_last;

   // ---------------------------------------------------------------------
   // operand capture
   // ---------------------------------------------------------------------
   assign w_accept = start && (r_state != ST_RUN);
   assign w_signed = ~op[OP_BIT_UNSIGNED];
   assign w_neg_a  = w_signed & a[W-1];
   assign w_neg_b  = w_signed & b[W-1];
   assign w_b_zero = (b == '0);
   // -2^31 negates to itself, which is the correct unsigned magnitude
   assign w_abs_a  = w_neg_a ? (~a + 1'b1) : a;
   assign w_abs_b  = w_neg_b ? (~b + 1'b1) : b;

   // ---------------------------------------------------------------------
   // shared 33-bit adder/subtractor
   //   multiply : {0,hi} + (lo[0] ? {0,M} : 0)
   //   divide   : {hi,lo[msb]} - {0,D}; bit W is the borrow/sign since the
   //              partial remainder is always below D
   // ---------------------------------------------------------------------
   assign w_wrk_hi = r_wrk[2*W-1:W];
   assign w_wrk_lo = r_wrk[W-1:0];

   always_comb begin
      w_add_x = {1'b0, w_wrk_hi};
      w_add_y = '0;
      w_add_c = 1'b0;
      if (r_is_div) begin
         w_add_x = {w_wrk_hi, w_wrk_lo[W-1]};
         w_add_y = ~{1'b0, r_opnd};
         w_add_c = 1'b1;
      end else if (w_wrk_lo[0]) begin
         w_add_y = {1'b0, r_opnd};
      end
   end

   assign w_sum = w_add_x + w_add_y + {{W{1'b0}}, w_add_c};

   always_comb begin
      w_nxt_hi = w_sum[W:1];
      w_nxt_lo = {w_sum[0], w_wrk_lo[W-1:1]};
      if (r_is_div) begin
         if (w_sum[W]) begin
            // restore: keep the shifted remainder, quotient bit 0
            w_nxt_hi = w_add_x[W-1:0];
            w_nxt_lo = {w_wrk_lo[W-2:0], 1'b0};
         end else begin
            w_nxt_hi = w_sum[W-1:0];
            w_nxt_lo = {w_wrk_lo[W-2:0], 1'b1};
         end
      end
   end

   // ---------------------------------------------------------------------
   // sign application on the last iteration's output
   // ---------------------------------------------------------------------
   assign w_prod_neg = ~{w_nxt_hi, w_nxt_lo} + 1'b1;

   always_comb begin
      w_res_hi = w_nxt_hi;
      w_res_lo = w_nxt_lo;
      if (r_is_div) begin
         if (r_neg_r) w_res_hi = ~w_nxt_hi + 1'b1;
         if (r_neg_q) w_res_lo = ~w_nxt_lo + 1'b1;
      end else if (r_neg_q) begin
         w_res_hi = w_prod_neg[2*W-1:W];
         w_res_lo = w_prod_neg[W-1:0];
      end
   end

   assign w_last = (r_cnt == 6'(MDU_ITERS - 1));

   // ---------------------------------------------------------------------
   // FSM and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_opnd   <= '0;
         r_wrk    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_accept) begin
                  r_state  <= ST_RUN;
                  r_cnt    <= '0;
                  r_is_div <= op[OP_BIT_DIV];
                  if (op[OP_BIT_DIV]) begin
                     r_opnd  <= w_abs_b;
                     r_wrk   <= {{W{1'b0}}, w_abs_a};
                     // a zero divisor yields an all-ones quotient that must
                     // not be negated; the remainder then equals a
                     r_neg_q <= (w_neg_a ^ w_neg_b) & ~w_b_zero;
                     r_neg_r <= w_neg_a;
                  end else begin
                     r_opnd  <= w_abs_a;
                     r_wrk   <= {{W{1'b0}}, w_abs_b};
                     r_neg_q <= w_neg_a ^ w_neg_b;
                     r_neg_r <= 1'b0;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_wrk <= {w_nxt_hi, w_nxt_lo};
               r_cnt <= r_cnt + 6'd1;
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
